nixie_scan_ctrl: RTL and testbench
==================================

# nixie_scan_ctrl

Parametrised multiplexed scan controller for common-anode seven-segment / nixie-style digit arrays. Time-multiplexes `DIGITS` hex digits onto one shared segment bus, drives the one-hot active-low digit select, applies per-slot PWM brightness and per-digit blanking, and double-buffers display data so updates take effect only on frame boundaries. Replaces the fixed 8-digit combinational select decoder; sits between the board-level display pins and any register or CPU block that supplies display values.

## Interface
Parameters:
- `DIGITS`, 8, number of multiplexed digits (1..16)
- `PHASE_LEN`, 3125, clock cycles per brightness phase; digit slot = 16 × `PHASE_LEN` cycles (≥1)

Ports:
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  display enable; 0 blanks outputs, counters keep running
- `load`  in  1  single-cycle strobe: capture `data`, `dp`, `blank`
- `data`  in  4×DIGITS  hex nibble per digit, digit i at [4i+3:4i]
- `dp`  in  DIGITS  decimal point request per digit, 1 = lit
- `blank`  in  DIGITS  per-digit blank, 1 = digit dark
- `brightness`  in  4  duty level, lit phases = brightness+1 (1/16..16/16)
- `sel`  out  DIGITS  digit select, one-hot active-low
- `seg`  out  8  segments active-low, [6:0] = g..a, [7] = dp
- `frame_done`  out  1  one-cycle pulse at each frame wrap

## Operation
- Counters: `pcnt` 0..PHASE_LEN-1; `phase` 0..15 advances when `pcnt` wraps; `idx` 0..DIGITS-1 advances when `phase` wraps 15→0; frame wrap = `idx` DIGITS-1→0 coincident with phase/pcnt wrap.
- `load`: `data`/`dp`/`blank` latched into pending register, `pend` flag set.
- Frame wrap with `pend`=1: pending copied to shadow, `pend` cleared. `load` on the frame-wrap cycle bypasses: shadow takes that cycle's inputs directly, `pend` stays 0.
- Only shadow drives outputs; mid-frame loads never tear a frame.
- `brightness` sampled live each cycle (no buffering).
- Lit condition: `en`=1 and `blank_sh[idx]`=0 and `phase` ≤ `brightness`.
- Lit: `sel` = ~(1<<idx), `seg` = {~dp_sh[idx], decode(data_sh[idx])}. Not lit: `sel` all 1s, `seg` = 8'hFF.
- Decode (active-low, dp excluded): 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.
- `DIGITS`=1: `idx` constant 0, every slot is a frame.

## Timing
- Reset values: `sel` all 1s, `seg` 8'hFF, `frame_done` 0, all counters 0, shadow/pending 0, `pend` 0.
- `sel`, `seg`, `frame_done` registered: reflect counter state with 1-cycle latency.
- Never more than one `sel` bit low; `sel`/`seg` change only on the same clock edge (no glitch between digits).
- `frame_done` high for exactly one cycle, the cycle after frame wrap; period = DIGITS × 16 × PHASE_LEN cycles.
- Shadow update visible on outputs the cycle after frame wrap (same cycle as `frame_done`).
- `rst` mid-frame: next cycle all state as reset; pending load discarded; scan restarts at digit 0 phase 0.
- `en` deassert/assert takes effect on outputs one cycle later; scan position unaffected.

## Structure
- Package `nixie_pkg`: segment encoding constants (SEG_BLANK = 8'hFF), hex→segment lookup function, `phase_t` (4-bit) typedef.
- Sub-module `seg7_decode`: combinational 4-bit hex → 7-bit active-low segment decoder; instantiated once on the muxed nibble.
- Top holds counters, pending/shadow registers, mux and output registers.

## Test plan
- Reset then run, DIGITS=4, PHASE_LEN=2, brightness=F, load data=16'h3210: `sel` cycles E,D,B,7 each 32 cycles; `seg` C0,F9,A4,B0; `frame_done` every 128 cycles.
- brightness=0: each digit lit 2 cycles per 32-cycle slot (phase 0 only), `sel`=F rest of slot; brightness=7 → 16 cycles lit.
- Load 16'hABCD mid-frame: outputs keep 3210 until frame wrap, then show D,C,B,A (A1,C6,83,88) from the `frame_done` cycle; `load` on frame-wrap cycle applies immediately.
- blank=4'b0010, dp=4'b0001: digit 1 slot `sel`=F/`seg`=FF; digit 0 `seg`=40 (dp lit on 0).
- `en` low mid-slot: next cycle `sel`=F, `seg`=FF; re-enable resumes at current scan position, frame_done period unchanged.
- Assert `rst` mid-frame with pending load: outputs return to reset values, pending data never displayed, scan restarts at digit 0.

Source files
------------

// File: rtl/nixie_pkg.sv
// nixie_pkg
//   Shared definitions for the multiplexed digit scan controller:
//   blank segment pattern, brightness phase type and the hex to
//   seven-segment (active-low, g..a) lookup used by seg7_decode.
package nixie_pkg;

    // All segments (including dp) dark on a common-anode array.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Brightness phases per digit slot; phase_t wraps naturally at 16.
    localparam int PHASES = 16;
    typedef logic [3:0] phase_t;

    // Hex nibble to active-low segments, bit 6 = g ... bit 0 = a.
    // The decimal point is handled separately by the caller.
    function automatic logic [6:0] hex2seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational hex to seven-segment decoder, active-low outputs.
//   Ports:
//     i_hex  in  4  hex nibble
//     o_seg  out 7  segments g..a, 0 = lit
module seg7_decode
    import nixie_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = hex2seg(i_hex);

endmodule

// File: rtl/nixie_scan_ctrl.sv
// nixie_scan_ctrl
//   Time-multiplexed scan controller for a common-anode digit array.
//   Each digit owns a slot of 16 brightness phases of PHASE_LEN cycles;
//   the digit is lit during phases 0..brightness. Display data is
//   double-buffered (pending -> shadow) and swapped only on frame wrap.
//   Ports:
//     clk         in   1         clock
//     rst         in   1         synchronous active-high reset
//     en          in   1         display enable (counters always run)
//     load        in   1         strobe: capture data/dp/blank
//     data        in   4*DIGITS  hex nibble per digit, digit i at [4i+3:4i]
//     dp          in   DIGITS    decimal point per digit, 1 = lit
//     blank       in   DIGITS    per-digit blank, 1 = dark
//     brightness  in   4         lit phases = brightness+1
//     sel         out  DIGITS    one-hot active-low digit select
//     seg         out  8         active-low segments, [7] = dp
//     frame_done  out  1         one-cycle pulse after each frame wrap
module nixie_scan_ctrl
    import nixie_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int PHASE_LEN = 3125
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic [3:0]            brightness,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int PCW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PCW-1:0] PC_LAST  = PCW'(PHASE_LEN - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);
    localparam phase_t         PH_LAST  = phase_t'(PHASES - 1);

    // Scan counters
    logic [PCW-1:0]      r_pcnt;
    phase_t              r_phase;
    logic [IW-1:0]       r_idx;

    // Pending (written by load) and shadow (drives outputs) buffers
    logic                r_pend;
    logic [4*DIGITS-1:0] r_data_pd;
    logic [DIGITS-1:0]   r_dp_pd;
    logic [DIGITS-1:0]   r_blank_pd;
    logic [4*DIGITS-1:0] r_data_sh;
    logic [DIGITS-1:0]   r_dp_sh;
    logic [DIGITS-1:0]   r_blank_sh;

    // Output registers
    logic [DIGITS-1:0]   r_sel;
    logic [7:0]          r_seg;
    logic                r_frame_done;

    logic                w_pwrap;
    logic                w_phwrap;
    logic                w_fwrap;
    logic [PCW-1:0]      w_pcnt_nxt;
    phase_t              w_phase_nxt;
    logic [IW-1:0]       w_idx_nxt;
    logic [4*DIGITS-1:0] w_data_sh_nxt;
    logic [DIGITS-1:0]   w_dp_sh_nxt;
    logic [DIGITS-1:0]   w_blank_sh_nxt;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg7;
    logic                w_dp_bit;
    logic                w_blank_bit;
    logic                w_lit;
    logic [DIGITS-1:0]   w_sel_nxt;
    logic [7:0]          w_seg_nxt;

    assign w_pwrap  = (r_pcnt == PC_LAST);
    assign w_phwrap = w_pwrap && (r_phase == PH_LAST);
    assign w_fwrap  = w_phwrap && (r_idx == IDX_LAST);

    // Next scan position
    always_comb begin
        w_pcnt_nxt  = r_pcnt + 1'b1;
        w_phase_nxt = r_phase;
        w_idx_nxt   = r_idx;
        if (w_pwrap) begin
            w_pcnt_nxt  = '0;
            w_phase_nxt = r_phase + 1'b1;
        end
        if (w_phwrap) begin
            if (r_idx == IDX_LAST) w_idx_nxt = '0;
            else                   w_idx_nxt = r_idx + 1'b1;
        end
    end

    // Shadow swap at frame wrap. A load landing exactly on the wrap cycle
    // goes straight to the shadow so it is not delayed by a whole frame.
    always_comb begin
        w_data_sh_nxt  = r_data_sh;
        w_dp_sh_nxt    = r_dp_sh;
        w_blank_sh_nxt = r_blank_sh;
        if (w_fwrap && load) begin
            w_data_sh_nxt  = data;
            w_dp_sh_nxt    = dp;
            w_blank_sh_nxt = blank;
        end else if (w_fwrap && r_pend) begin
            w_data_sh_nxt  = r_data_pd;
            w_dp_sh_nxt    = r_dp_pd;
            w_blank_sh_nxt = r_blank_pd;
        end
    end

    // Output mux works on the next scan position and next shadow so the
    // registered outputs line up with the counters: the new frame's data
    // and digit 0 appear in the same cycle as frame_done.
    assign w_nib       = w_data_sh_nxt[{w_idx_nxt, 2'b00} +: 4];
    assign w_dp_bit    = w_dp_sh_nxt[w_idx_nxt];
    assign w_blank_bit = w_blank_sh_nxt[w_idx_nxt];
    assign w_lit       = en && !w_blank_bit && (w_phase_nxt <= brightness);

    seg7_decode u_dec (
        .i_hex (w_nib),
        .o_seg (w_seg7)
    );

    always_comb begin
        w_sel_nxt = '1;
        w_seg_nxt = SEG_BLANK;
        if (w_lit) begin
            w_sel_nxt[w_idx_nxt] = 1'b0;
            w_seg_nxt            = {~w_dp_bit, w_seg7};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt       <= '0;
            r_phase      <= '0;
            r_idx        <= '0;
            r_pend       <= 1'b0;
            r_data_pd    <= '0;
            r_dp_pd      <= '0;
            r_blank_pd   <= '0;
            r_data_sh    <= '0;
            r_dp_sh      <= '0;
            r_blank_sh   <= '0;
            r_sel        <= '1;
            r_seg        <= SEG_BLANK;
            r_frame_done <= 1'b0;
        end else begin
            r_pcnt       <= w_pcnt_nxt;
            r_phase      <= w_phase_nxt;
            r_idx        <= w_idx_nxt;
            r_data_sh    <= w_data_sh_nxt;
            r_dp_sh      <= w_dp_sh_nxt;
            r_blank_sh   <= w_blank_sh_nxt;
            r_sel        <= w_sel_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_fwrap;
            if (w_fwrap) begin
                r_pend <= 1'b0;
            end else if (load) begin
                r_pend     <= 1'b1;
                r_data_pd  <= data;
                r_dp_pd    <= dp;
                r_blank_pd <= blank;
            end
        end
    end

    assign sel        = r_sel;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_nixie_scan_ctrl.sv
module tb_nixie_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int PL     = 2;
    localparam int SLOT   = 16 * PL;
    localparam int FRAME  = DIGITS * SLOT;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  brightness;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic        frame_done;

    nixie_scan_ctrl #(.DIGITS(DIGITS), .PHASE_LEN(PL)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .data       (data),
        .dp         (dp),
        .blank      (blank),
        .brightness (brightness),
        .sel        (sel),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: scan position derived from elapsed cycles since reset
    int          mt;
    logic [15:0] m_d_sh, m_d_pd;
    logic [3:0]  m_dp_sh, m_dp_pd, m_bl_sh, m_bl_pd;
    bit          m_pend;
    int          cyc;
    int          last_fd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        exp_t       e;
        exp_t       o;
        int         nt, id, ph;
        bit         fw, lit;
        logic [3:0] oh, nib;
        logic [7:0] sv;
        if (rst) begin
            mt = 0; m_pend = 0;
            m_d_sh = '0; m_dp_sh = '0; m_bl_sh = '0;
            m_d_pd = '0; m_dp_pd = '0; m_bl_pd = '0;
            e.sel = 4'hF; e.seg = 8'hFF; e.fd = 1'b0;
        end else begin
            nt = mt + 1;
            fw = (nt % FRAME) == 0;
            if (fw) begin
                if (load) begin
                    m_d_sh = data; m_dp_sh = dp; m_bl_sh = blank;
                end else if (m_pend) begin
                    m_d_sh = m_d_pd; m_dp_sh = m_dp_pd; m_bl_sh = m_bl_pd;
                end
                m_pend = 0;
            end else if (load) begin
                m_d_pd = data; m_dp_pd = dp; m_bl_pd = blank; m_pend = 1;
            end
            id  = (nt / SLOT) % DIGITS;
            ph  = (nt / PL) % 16;
            lit = en && !m_bl_sh[id] && (ph <= int'(brightness));
            oh  = 4'b0001 << id;
            nib = m_d_sh[id*4 +: 4];
            sv  = seg_tbl[nib];
            e.sel = lit ? ~oh : 4'hF;
            e.seg = lit ? {~m_dp_sh[id], sv[6:0]} : 8'hFF;
            e.fd  = fw;
            mt = nt;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            o = sb_q.pop_front();
            chk("sel", 32'(sel), 32'(o.sel));
            chk("seg", 32'(seg), 32'(o.seg));
            chk("frame_done", 32'(frame_done), 32'(o.fd));
            chk("sel_onehot", 32'($countones(~sel) <= 1), 32'd1);
        end
        if (rst) begin
            cyc = 0; last_fd = 0;
        end else begin
            cyc++;
            if (frame_done === 1'b1) begin
                chk("fd_period", 32'(cyc - last_fd), 32'(FRAME));
                last_fd = cyc;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data = d; dp = p; blank = b; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Advance until the counters sit on the last cycle of a frame
    task automatic to_wrap_cycle();
        while ((mt % FRAME) != FRAME - 1) step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0;
        data = '0; dp = '0; blank = '0; brightness = 4'hF;
        mt = 0; m_pend = 0; cyc = 0; last_fd = 0;
        m_d_sh = '0; m_dp_sh = '0; m_bl_sh = '0;
        m_d_pd = '0; m_dp_pd = '0; m_bl_pd = '0;

        run(3);
        rst = 1'b0;

        // Basic scan, data captured mid-frame shows from the next frame
        pulse_load(16'h3210, 4'h0, 4'h0);
        run(300);

        // Brightness extremes
        brightness = 4'h0; run(FRAME);
        brightness = 4'h7; run(FRAME);
        brightness = 4'hF;

        // Mid-frame load must not tear the current frame
        run(40);
        pulse_load(16'hABCD, 4'h0, 4'h0);
        run(150);

        // Load on the wrap cycle applies immediately
        to_wrap_cycle();
        pulse_load(16'h5678, 4'h0, 4'h0);
        run(64);

        // Blank and decimal point
        pulse_load(16'h3210, 4'b0001, 4'b0010);
        run(300);

        // Enable drop mid-slot
        run(10);
        en = 1'b0; run(20);
        en = 1'b1; run(200);

        // Reset mid-frame with a pending load
        run(50);
        pulse_load(16'h9999, 4'hF, 4'h0);
        run(5);
        rst = 1'b1; step();
        rst = 1'b0;
        run(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
